// File: rtl/gate_pkg.sv
// Shared definitions for the gate array: logic-function encoding,
// parameter limits and the per-gate function helper.
package gate_pkg;

  // Logic function applied by every channel.
  typedef enum logic [1:0] {
    GATE_NAND = 2'd0,
    GATE_AND  = 2'd1,
    GATE_NOR  = 2'd2,
    GATE_OR   = 2'd3
  } gate_mode_t;

  // Legal parameter ranges.
  localparam int unsigned CHANNELS_MIN = 32'd1;
  localparam int unsigned CHANNELS_MAX = 32'd16;
  localparam int unsigned INPUTS_MIN   = 32'd2;
  localparam int unsigned INPUTS_MAX   = 32'd8;
  localparam int unsigned DELAY_MIN    = 32'd1;
  localparam int unsigned DELAY_MAX    = 32'd8;
  localparam int unsigned FILTER_MIN   = 32'd1;
  localparam int unsigned FILTER_MAX   = 32'd15;

  // Width of the glitch-filter stability counter.
  localparam int unsigned FILT_CNT_W   = 32'd4;

  // Reduce a gate to its function using only "all inputs high" and
  // "any input high"; this keeps the helper independent of INPUTS.
  function automatic logic gate_apply(input gate_mode_t mode,
                                      input logic       all_ones,
                                      input logic       any_one);
    logic res;
    case (mode)
      GATE_NAND: res = ~all_ones;
      GATE_AND:  res = all_ones;
      GATE_NOR:  res = ~any_one;
      GATE_OR:   res = any_one;
      default:   res = ~all_ones;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_channel.sv
// One gate of the array: function evaluation, DELAY-deep pipeline,
// optional glitch filter (GATE_GLITCH_FILTER_EN) and y/changed registers.
module gate_channel
  import gate_pkg::*;
#(
  parameter int unsigned INPUTS    = 32'd3,
  parameter int unsigned DELAY     = 32'd1,
  parameter int unsigned FILTER    = 32'd2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  gate_mode_t        mode,
  input  logic [INPUTS-1:0] slice,
  output logic              y,
  output logic              changed
);

  // Reject out-of-range configurations at elaboration time.
  if (INPUTS < INPUTS_MIN || INPUTS > INPUTS_MAX ||
      DELAY < DELAY_MIN || DELAY > DELAY_MAX ||
      FILTER < FILTER_MIN || FILTER > FILTER_MAX) begin : g_param_err
    $error("gate_channel: parameter out of range");
  end

  logic             raw_s;
  logic [DELAY-1:0] pipe_q;
  logic [DELAY-1:0] pipe_d;
  logic             last_s;
  logic             y_q;
  logic             y_d;
  logic             changed_q;
  logic             changed_d;

  // Raw gate result for the current cycle's inputs and mode.
  always_comb begin
    raw_s = gate_apply(mode, &slice, |slice);
  end

  // Shift the raw result into stage 0; the oldest value leaves the top.
  if (DELAY == 32'd1) begin : g_pipe_one
    always_comb begin
      pipe_d = raw_s;
    end
  end else begin : g_pipe_many
    always_comb begin
      pipe_d = {pipe_q[DELAY-2:0], raw_s};
    end
  end

  assign last_s = pipe_q[DELAY-1];

`ifdef GATE_GLITCH_FILTER_EN
  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER - 32'd1);

  logic [FILT_CNT_W-1:0] cnt_q;
  logic [FILT_CNT_W-1:0] cnt_d;

  // Commit a new value only after it has differed from y for FILTER edges.
  always_comb begin
    y_d   = y_q;
    cnt_d = {FILT_CNT_W{1'b0}};
    if (last_s == y_q) begin
      cnt_d = {FILT_CNT_W{1'b0}};
    end else if (cnt_q >= CNT_LAST) begin
      y_d   = last_s;
      cnt_d = {FILT_CNT_W{1'b0}};
    end else if (cnt_q == {FILT_CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + FILT_CNT_W'(1);
    end
  end

  // Stability counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {FILT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the filter y simply follows the last pipeline stage.
  always_comb begin
    y_d = last_s;
  end
`endif

  // A toggle of y is flagged in the same cycle it is committed.
  always_comb begin
    changed_d = y_d ^ y_q;
  end

  // Pipeline, output and change-flag registers; reset drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q    <= {DELAY{RESET_VAL}};
      y_q       <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      pipe_q    <= pipe_d;
      y_q       <= y_d;
      changed_q <= changed_d;
    end
  end

  assign y       = y_q;
  assign changed = changed_q;

endmodule

// File: rtl/nand_gate_array.sv
// Array of CHANNELS registered, mode-selectable gates with TTL-like delay.
// Optional glitch filter enabled by defining GATE_GLITCH_FILTER_EN.
module nand_gate_array
  import gate_pkg::*;
#(
  parameter int unsigned CHANNELS  = 32'd4,
  parameter int unsigned INPUTS    = 32'd3,
  parameter int unsigned DELAY     = 32'd1,
  parameter int unsigned FILTER    = 32'd2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [CHANNELS*INPUTS-1:0] in,
  output logic [CHANNELS-1:0]        y,
  output logic [CHANNELS-1:0]        changed
);

  gate_mode_t mode_s;

  assign mode_s = gate_mode_t'(mode);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gate_channel #(
      .INPUTS    (INPUTS),
      .DELAY     (DELAY),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode_s),
      .slice   (in[c*INPUTS +: INPUTS]),
      .y       (y[c]),
      .changed (changed[c])
    );
  end

endmodule

// File: tb/tb_nand_gate_array.sv
// Randomised self-checking bench: two arrays (DELAY=1 and DELAY=4) share
// the same stimulus and are compared against a history-based reference.
module tb_nand_gate_array;

  localparam int   CH   = 4;
  localparam int   IN   = 3;
  localparam int   FILT = 3;
  localparam logic RV   = 1'b1;
  localparam int   MAXE = 2048;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [CH*IN-1:0] in_s;
  logic [CH-1:0]    y1, c1, y4, c4;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  logic [CH-1:0] raw_h [MAXE];
  bit            rst_h [MAXE];
  logic [CH-1:0] ym    [2];
  int            runs  [2][CH];

  always #5 clk = ~clk;

  nand_gate_array #(.CHANNELS(CH), .INPUTS(IN), .DELAY(1), .FILTER(FILT), .RESET_VAL(RV)) u_dut_d1 (
    .clk(clk), .rst(rst), .mode(mode), .in(in_s), .y(y1), .changed(c1));

  nand_gate_array #(.CHANNELS(CH), .INPUTS(IN), .DELAY(4), .FILTER(FILT), .RESET_VAL(RV)) u_dut_d4 (
    .clk(clk), .rst(rst), .mode(mode), .in(in_s), .y(y4), .changed(c4));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // Gate function from the count of high inputs in each slice.
  function automatic logic [CH-1:0] model_raw(input logic [1:0] m, input logic [CH*IN-1:0] v);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) begin
      int n;
      n = $countones(v[c*IN +: IN]);
      case (m)
        2'd0:    r[c] = (n != IN);
        2'd1:    r[c] = (n == IN);
        2'd2:    r[c] = (n == 0);
        default: r[c] = (n != 0);
      endcase
    end
    return r;
  endfunction

  // Value of the last delay stage after edge ee: the raw value sampled d-1
  // edges earlier, unless a reset (or time before start) lies in between.
  function automatic logic [CH-1:0] stage_val(input int d, input int ee);
    if (ee - d + 1 < 0) return {CH{RV}};
    for (int k = ee - d + 1; k <= ee; k++)
      if (rst_h[k]) return {CH{RV}};
    return raw_h[ee - d + 1];
  endfunction

  // Advance the expected y of instance idx over edge e; returns expected changed.
  task automatic model_step(input int idx, input int d, output logic [CH-1:0] yexp,
                            output logic [CH-1:0] cexp);
    logic [CH-1:0] yn;
    logic [CH-1:0] s;
    yn = ym[idx];
    if (rst_h[e]) begin
      yn = {CH{RV}};
      for (int c = 0; c < CH; c++) runs[idx][c] = 0;
      cexp = '0;
    end else begin
      s = stage_val(d, e - 1);
`ifdef GATE_GLITCH_FILTER_EN
      for (int c = 0; c < CH; c++) begin
        if (s[c] == ym[idx][c]) begin
          runs[idx][c] = 0;
        end else begin
          runs[idx][c]++;
          if (runs[idx][c] >= FILT) begin
            yn[c] = s[c];
            runs[idx][c] = 0;
          end
        end
      end
`else
      yn = s;
`endif
      cexp = yn ^ ym[idx];
    end
    ym[idx] = yn;
    yexp = yn;
  endtask

  task automatic cycle(input logic r, input logic [1:0] m, input logic [CH*IN-1:0] v);
    logic [CH-1:0] ye, ce;
    rst  = r;
    mode = m;
    in_s = v;
    @(posedge clk);
    raw_h[e] = model_raw(m, v);
    rst_h[e] = r;
    #1;
    model_step(0, 1, ye, ce);
    check_eq("y_d1", 32'(y1), 32'(ye));
    check_eq("changed_d1", 32'(c1), 32'(ce));
    model_step(1, 4, ye, ce);
    check_eq("y_d4", 32'(y4), 32'(ye));
    check_eq("changed_d4", 32'(c4), 32'(ce));
    e++;
    @(negedge clk);
  endtask

  initial begin
    logic [CH*IN-1:0] v;
    logic [1:0]       m;
    logic [1:0]       modes [4];
    ym[0] = {CH{RV}};
    ym[1] = {CH{RV}};
    for (int c = 0; c < CH; c++) begin
      runs[0][c] = 0;
      runs[1][c] = 0;
    end
    rst = 1'b1; mode = 2'd0; in_s = '1;
    @(negedge clk);

    // Reset held three cycles with all inputs high under NAND.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 12'hFFF);
    for (int i = 0; i < 2; i++) cycle(1'b0, 2'd0, 12'hFFF);

    // Truth table: ch0=111, ch1=011 through NAND, OR, NOR, AND.
    modes[0] = 2'd0; modes[1] = 2'd3; modes[2] = 2'd2; modes[3] = 2'd1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 6; i++) cycle(1'b0, modes[k], 12'h01F);

    // Latency step on channel 2 under NAND.
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 12'h01F);
    for (int i = 0; i < 7; i++) cycle(1'b0, 2'd0, 12'h1DF);

    // Raw pulses of 1, 2 and 3 cycles on channel 0.
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) cycle(1'b0, 2'd0, 12'h1DB);
      for (int i = 0; i < 8; i++) cycle(1'b0, 2'd0, 12'h1DF);
    end

    // Simultaneous toggle on all channels, reset one edge before DELAY=4 commits.
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 12'h000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 12'hFFF);
    cycle(1'b1, 2'd0, 12'hFFF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'd0, 12'hFFF);

    // Random phase: held input values of random length, occasional resets.
    m = 2'd0;
    v = '0;
    for (int i = 0; i < 120; i++) begin
      int hold;
      logic r;
      v = 12'($urandom);
      if ($urandom_range(0, 5) == 0) m = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        r = ($urandom_range(0, 40) == 0);
        cycle(r, m, v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
